// File: rtl/conv2_window_buf.sv
// conv2_window_buf: raster-stream line buffer that emits 5x5 pixel windows.
// Pixels enter a shift buffer long enough to span four full rows plus one
// window width. When the pixel being accepted completes a window (row and
// column both at least FILTER_SIZE-1), the 25 window pixels are registered
// onto data_out_* together with a one-cycle valid_out pulse.
// Handshake: valid_in qualifies data_in for one cycle, and there is no
// ready/backpressure. valid_out is a one-cycle pulse that the consumer must
// take. data_out_* hold their last window between pulses.
module conv2_window_buf #(
   parameter int WIDTH       = 12,
   parameter int HEIGHT      = 12,
   parameter int FILTER_SIZE = 5,
   parameter int DATA_BITS   = 12
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in,
   input  logic [DATA_BITS-1:0] data_in,
   output logic [DATA_BITS-1:0] data_out_0,
   output logic [DATA_BITS-1:0] data_out_1,
   output logic [DATA_BITS-1:0] data_out_2,
   output logic [DATA_BITS-1:0] data_out_3,
   output logic [DATA_BITS-1:0] data_out_4,
   output logic [DATA_BITS-1:0] data_out_5,
   output logic [DATA_BITS-1:0] data_out_6,
   output logic [DATA_BITS-1:0] data_out_7,
   output logic [DATA_BITS-1:0] data_out_8,
   output logic [DATA_BITS-1:0] data_out_9,
   output logic [DATA_BITS-1:0] data_out_10,
   output logic [DATA_BITS-1:0] data_out_11,
   output logic [DATA_BITS-1:0] data_out_12,
   output logic [DATA_BITS-1:0] data_out_13,
   output logic [DATA_BITS-1:0] data_out_14,
   output logic [DATA_BITS-1:0] data_out_15,
   output logic [DATA_BITS-1:0] data_out_16,
   output logic [DATA_BITS-1:0] data_out_17,
   output logic [DATA_BITS-1:0] data_out_18,
   output logic [DATA_BITS-1:0] data_out_19,
   output logic [DATA_BITS-1:0] data_out_20,
   output logic [DATA_BITS-1:0] data_out_21,
   output logic [DATA_BITS-1:0] data_out_22,
   output logic [DATA_BITS-1:0] data_out_23,
   output logic [DATA_BITS-1:0] data_out_24,
   output logic                 valid_out
);

   localparam int DEPTH = WIDTH * (FILTER_SIZE - 1) + FILTER_SIZE;
   localparam int NWIN  = FILTER_SIZE * FILTER_SIZE;
   localparam int CW    = $clog2(WIDTH);
   localparam int RW    = $clog2(HEIGHT);

   localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
   localparam logic [CW-1:0] COL_MIN  = CW'(FILTER_SIZE - 1);
   localparam logic [RW-1:0] ROW_MIN  = RW'(FILTER_SIZE - 1);

   logic [DATA_BITS-1:0] shift_q [DEPTH];
   logic [DATA_BITS-1:0] shift_d [DEPTH];
   logic [DATA_BITS-1:0] win_q   [NWIN];
   logic [CW-1:0]        col_q;
   logic [RW-1:0]        row_q;
   logic                 accept;
   logic                 fire;
   logic                 valid_q;

   // A pixel is accepted on any valid cycle that is not a reset cycle.
   // It completes a window only once the counters are past the top and left
   // borders, which also keeps stale pixels from the previous row or frame out.
   always_comb begin
      accept = valid_in && !rst;
      fire   = accept && (row_q >= ROW_MIN) && (col_q >= COL_MIN);
   end

   // Buffer contents as they will be after this accept: entry k holds the pixel accepted k accepts ago.
   always_comb begin
      shift_d[0] = data_in;
      for (int k = 1; k < DEPTH; k++) begin
         shift_d[k] = shift_q[k-1];
      end
   end

   // Shift buffer advances only on accepted pixels. It needs no reset because firing is counter-gated.
   always_ff @(posedge clk) begin
      if (accept) begin
         shift_q <= shift_d;
      end
   end

   // Raster position of the pixel being accepted. It wraps per row and per frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
      end else if (accept) begin
         if (col_q == COL_LAST) begin
            col_q <= '0;
            if (row_q == ROW_LAST) begin
               row_q <= '0;
            end else begin
               row_q <= row_q + 1'b1;
            end
         end else begin
            col_q <= col_q + 1'b1;
         end
      end
   end

   // Register the window taken from the post-shift view. Window (i,j) is (FS-1-i) rows and (FS-1-j) cols back.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < NWIN; k++) begin
            win_q[k] <= '0;
         end
      end else if (fire) begin
         for (int i = 0; i < FILTER_SIZE; i++) begin
            for (int j = 0; j < FILTER_SIZE; j++) begin
               win_q[i*FILTER_SIZE + j] <= shift_d[(FILTER_SIZE-1-i)*WIDTH + (FILTER_SIZE-1-j)];
            end
         end
      end
   end

   // One-cycle pulse following each window-completing accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= fire;
      end
   end

   assign valid_out   = valid_q;
   assign data_out_0  = win_q[0];
   assign data_out_1  = win_q[1];
   assign data_out_2  = win_q[2];
   assign data_out_3  = win_q[3];
   assign data_out_4  = win_q[4];
   assign data_out_5  = win_q[5];
   assign data_out_6  = win_q[6];
   assign data_out_7  = win_q[7];
   assign data_out_8  = win_q[8];
   assign data_out_9  = win_q[9];
   assign data_out_10 = win_q[10];
   assign data_out_11 = win_q[11];
   assign data_out_12 = win_q[12];
   assign data_out_13 = win_q[13];
   assign data_out_14 = win_q[14];
   assign data_out_15 = win_q[15];
   assign data_out_16 = win_q[16];
   assign data_out_17 = win_q[17];
   assign data_out_18 = win_q[18];
   assign data_out_19 = win_q[19];
   assign data_out_20 = win_q[20];
   assign data_out_21 = win_q[21];
   assign data_out_22 = win_q[22];
   assign data_out_23 = win_q[23];
   assign data_out_24 = win_q[24];

endmodule

// File: tb/tb_conv2_window_buf.sv
// Testbench for conv2_window_buf. A reference model builds each expected
// window from its own image of the current frame. The expected windows are
// queued when the triggering pixel is accepted. They are popped and compared
// when valid_out fires.
module tb_conv2_window_buf;

   localparam int DB = 12;
   localparam int WW = 25 * DB;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          valid_in = 1'b0;
   logic [DB-1:0] data_in = '0;
   logic [DB-1:0] dout [25];
   logic          valid_out;

   int n_checks = 0;
   int n_fail   = 0;
   int pulse_cnt = 0;
   bit mon_en = 1'b0;

   logic [WW-1:0] exp_q [$];
   logic [WW-1:0] obs_q [$];
   logic [WW-1:0] exp_hold = '0;
   logic          exp_fire = 1'b0;
   logic [DB-1:0] img [12][12];
   int            m_row = 0;
   int            m_col = 0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   conv2_window_buf dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in),
      .data_out_0(dout[0]),   .data_out_1(dout[1]),   .data_out_2(dout[2]),
      .data_out_3(dout[3]),   .data_out_4(dout[4]),   .data_out_5(dout[5]),
      .data_out_6(dout[6]),   .data_out_7(dout[7]),   .data_out_8(dout[8]),
      .data_out_9(dout[9]),   .data_out_10(dout[10]), .data_out_11(dout[11]),
      .data_out_12(dout[12]), .data_out_13(dout[13]), .data_out_14(dout[14]),
      .data_out_15(dout[15]), .data_out_16(dout[16]), .data_out_17(dout[17]),
      .data_out_18(dout[18]), .data_out_19(dout[19]), .data_out_20(dout[20]),
      .data_out_21(dout[21]), .data_out_22(dout[22]), .data_out_23(dout[23]),
      .data_out_24(dout[24]),
      .valid_out(valid_out)
   );

   function automatic logic [DB-1:0] px(input logic [WW-1:0] w, input int k);
      return w[k*DB +: DB];
   endfunction

   // ---------------- reference model (input side) ----------------
   always @(posedge clk) begin
      logic [WW-1:0] w;
      if (rst) begin
         m_row = 0;
         m_col = 0;
         exp_fire = 1'b0;
         exp_hold = '0;
      end else begin
         exp_fire = 1'b0;
         if (valid_in) begin
            img[m_row][m_col] = data_in;
            if (m_row >= 4 && m_col >= 4) begin
               for (int i = 0; i < 5; i++)
                  for (int j = 0; j < 5; j++)
                     w[(5*i+j)*DB +: DB] = img[m_row-4+i][m_col-4+j];
               exp_q.push_back(w);
               exp_hold = w;
               exp_fire = 1'b1;
            end
            if (m_col == 11) begin
               m_col = 0;
               m_row = (m_row == 11) ? 0 : m_row + 1;
            end else begin
               m_col = m_col + 1;
            end
         end
      end
   end

   // ---------------- scoreboard (output side) ----------------
   always @(negedge clk) begin
      logic [WW-1:0] cur;
      logic [WW-1:0] e;
      if (mon_en) begin
         for (int k = 0; k < 25; k++) cur[k*DB +: DB] = dout[k];
         n_checks++;
         if (valid_out !== exp_fire) begin
            n_fail++;
            $display("FAIL valid_out timing: got %b expected %b at %0t", valid_out, exp_fire, $time);
         end
         if (valid_out === 1'b1) begin
            pulse_cnt++;
            obs_q.push_back(cur);
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL window unexpected: got %h expected no window", cur);
            end else begin
               e = exp_q.pop_front();
               if (cur !== e) begin
                  n_fail++;
                  $display("FAIL window data: got %h expected %h", cur, e);
               end
            end
         end
         n_checks++;
         if (cur !== exp_hold) begin
            n_fail++;
            $display("FAIL data_out hold: got %h expected %h at %0t", cur, exp_hold, $time);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic drive_pixel(input logic [DB-1:0] d);
      @(negedge clk);
      valid_in = 1'b1;
      data_in  = d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         valid_in = 1'b0;
         data_in  = DB'($urandom_range(0, 4095));
      end
   endtask

   task automatic drive_frame(input bit gappy);
      for (int d = 0; d < 144; d++) begin
         if (gappy) begin
            for (int g = 0; g < 20 && $urandom_range(0, 1) == 0; g++) idle(1);
         end
         drive_pixel(DB'(d));
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      rst = 1'b1;
      valid_in = 1'b1;
      data_in = 12'hABC;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      n_checks++;
      if (valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset valid_out: got %b expected 0", valid_out);
      end
      for (int k = 0; k < 25; k++) begin
         n_checks++;
         if (dout[k] !== '0) begin
            n_fail++;
            $display("FAIL reset data_out_%0d: got %h expected 0", k, dout[k]);
         end
      end
      rst = 1'b0;
      valid_in = 1'b0;
   endtask

   task automatic test_contiguous;
      int idx;
      obs_q.delete();
      pulse_cnt = 0;
      drive_frame(1'b0);
      idle(3);
      n_checks++;
      if (pulse_cnt != 64) begin
         n_fail++;
         $display("FAIL contiguous pulse count: got %0d expected 64", pulse_cnt);
      end
      if (obs_q.size() == 64) begin
         n_checks++;
         if (px(obs_q[0], 0) !== 12'd0 || px(obs_q[0], 4) !== 12'd4 ||
             px(obs_q[0], 5) !== 12'd12 || px(obs_q[0], 24) !== 12'd52) begin
            n_fail++;
            $display("FAIL first window: got d0=%0d d4=%0d d5=%0d d24=%0d expected 0 4 12 52",
                     px(obs_q[0], 0), px(obs_q[0], 4), px(obs_q[0], 5), px(obs_q[0], 24));
         end
         n_checks++;
         if (px(obs_q[63], 0) !== 12'd91 || px(obs_q[63], 24) !== 12'd143) begin
            n_fail++;
            $display("FAIL last window: got d0=%0d d24=%0d expected 91 143",
                     px(obs_q[63], 0), px(obs_q[63], 24));
         end
         n_checks++;
         if (px(obs_q[7], 24) !== 12'd59 || px(obs_q[8], 24) !== 12'd64 || px(obs_q[8], 0) !== 12'd12) begin
            n_fail++;
            $display("FAIL row wrap: got w7.d24=%0d w8.d24=%0d w8.d0=%0d expected 59 64 12",
                     px(obs_q[7], 24), px(obs_q[8], 24), px(obs_q[8], 0));
         end
         for (int k = 0; k < 64; k++) begin
            idx = (4 + k / 8) * 12 + (4 + k % 8);
            n_checks++;
            if (px(obs_q[k], 24) !== DB'(idx) || px(obs_q[k], 0) !== DB'(idx - 52)) begin
               n_fail++;
               $display("FAIL contiguous order %0d: got d0=%0d d24=%0d expected %0d %0d",
                        k, px(obs_q[k], 0), px(obs_q[k], 24), idx - 52, idx);
            end
         end
      end
   endtask

   task automatic test_gappy;
      int idx;
      obs_q.delete();
      pulse_cnt = 0;
      drive_frame(1'b1);
      idle(3);
      n_checks++;
      if (pulse_cnt != 64) begin
         n_fail++;
         $display("FAIL gappy pulse count: got %0d expected 64", pulse_cnt);
      end
      if (obs_q.size() == 64) begin
         for (int k = 0; k < 64; k++) begin
            idx = (4 + k / 8) * 12 + (4 + k % 8);
            n_checks++;
            if (px(obs_q[k], 24) !== DB'(idx) || px(obs_q[k], 12) !== DB'(idx - 26)) begin
               n_fail++;
               $display("FAIL gappy order %0d: got d12=%0d d24=%0d expected %0d %0d",
                        k, px(obs_q[k], 12), px(obs_q[k], 24), idx - 26, idx);
            end
         end
      end
   endtask

   task automatic test_back_to_back;
      obs_q.delete();
      pulse_cnt = 0;
      drive_frame(1'b0);
      drive_frame(1'b0);
      idle(3);
      n_checks++;
      if (pulse_cnt != 128) begin
         n_fail++;
         $display("FAIL back-to-back pulse count: got %0d expected 128", pulse_cnt);
      end
      if (obs_q.size() == 128) begin
         n_checks++;
         if (px(obs_q[63], 24) !== 12'd143 || px(obs_q[64], 24) !== 12'd52 || px(obs_q[64], 0) !== 12'd0) begin
            n_fail++;
            $display("FAIL frame boundary: got w63.d24=%0d w64.d24=%0d w64.d0=%0d expected 143 52 0",
                     px(obs_q[63], 24), px(obs_q[64], 24), px(obs_q[64], 0));
         end
      end
   endtask

   task automatic test_mid_reset;
      for (int d = 0; d <= 70; d++) drive_pixel(DB'(d));
      @(negedge clk);
      rst = 1'b1;
      valid_in = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      n_checks++;
      if (valid_out !== 1'b0) begin
         n_fail++;
         $display("FAIL mid reset valid_out: got %b expected 0", valid_out);
      end
      for (int k = 0; k < 25; k++) begin
         n_checks++;
         if (dout[k] !== '0) begin
            n_fail++;
            $display("FAIL mid reset data_out_%0d: got %h expected 0", k, dout[k]);
         end
      end
      obs_q.delete();
      pulse_cnt = 0;
      drive_frame(1'b0);
      idle(3);
      n_checks++;
      if (pulse_cnt != 64 || obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL post reset pulse count: got %0d expected 64", pulse_cnt);
      end else begin
         n_checks++;
         if (px(obs_q[0], 0) !== 12'd0 || px(obs_q[0], 24) !== 12'd52) begin
            n_fail++;
            $display("FAIL post reset first window: got d0=%0d d24=%0d expected 0 52",
                     px(obs_q[0], 0), px(obs_q[0], 24));
         end
      end
   endtask

   task automatic test_rst_with_valid;
      for (int d = 0; d <= 30; d++) drive_pixel(DB'(d));
      @(negedge clk);
      rst = 1'b1;
      valid_in = 1'b1;
      data_in = 12'hFFF;
      @(negedge clk);
      rst = 1'b0;
      valid_in = 1'b0;
      obs_q.delete();
      pulse_cnt = 0;
      drive_frame(1'b0);
      idle(3);
      n_checks++;
      if (pulse_cnt != 64 || obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL rst+valid pulse count: got %0d expected 64", pulse_cnt);
      end else begin
         n_checks++;
         if (px(obs_q[0], 0) !== 12'd0 || px(obs_q[0], 24) !== 12'd52 || px(obs_q[0], 6) !== 12'd13) begin
            n_fail++;
            $display("FAIL rst+valid first window: got d0=%0d d6=%0d d24=%0d expected 0 13 52",
                     px(obs_q[0], 0), px(obs_q[0], 6), px(obs_q[0], 24));
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_contiguous();
      test_gappy();
      test_back_to_back();
      test_mid_reset();
      test_rst_with_valid();
      idle(2);
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/conv2_window_buf.md
Name: conv2_window_buf

Overview:
- Sliding-window line buffer that produces 5x5 pixel windows for the conv2 calc stage.
- Accepts the pool1 feature map as a raster stream of 12-bit pixels, one pixel per valid_in cycle.
- Each time a full 5x5 window is available, it presents 25 registered pixels on data_out_0..data_out_24 with a one-cycle valid_out pulse.
- Outputs connect directly to the conv2 calc stage's out_data_0..24 and valid_in ports.

Parameters:
- WIDTH, 12, feature-map columns.
- HEIGHT, 12, feature-map rows.
- FILTER_SIZE, 5, window edge; the window has 25 outputs, fixed by the port list.
- DATA_BITS, 12, pixel width.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- valid_in  input  1  data_in carries a pixel this cycle.
- data_in  input  DATA_BITS  raster-order pixel, row-major, passed through bit-exact.
- data_out_0 .. data_out_24  output  DATA_BITS each  window pixel (i,j) on data_out_(5*i+j), where i = row offset 0..4 and j = col offset 0..4 from the top-left.
- valid_out  output  1  one-cycle pulse: data_out_* hold a new window.

Behaviour:
- Storage: shift buffer of WIDTH*(FILTER_SIZE-1)+FILTER_SIZE = 53 entries.
  - Shifts only on cycles with valid_in=1; the newest pixel enters at entry 0.
  - No shift and no counter change when valid_in=0 (arbitrary gaps allowed).
- Counters: col (0..WIDTH-1) and row (0..HEIGHT-1) give the position of the pixel being accepted.
  - On accept: col increments; at WIDTH-1, col wraps to 0 and row increments.
  - At (HEIGHT-1, WIDTH-1), both wrap to 0; the next accepted pixel is (0,0) of a new frame. No idle cycle is required between frames.
- Window condition: an accepted pixel at (r,c) with r>=4 and c>=4 triggers a window.
  - On the next rising edge, valid_out=1 and data_out_(5i+j) = pixel (r-4+i, c-4+j).
  - data_out_24 = the pixel just accepted; data_out_0 = the pixel 52 accepts earlier.
- Latency: exactly 1 cycle from accepting the triggering pixel to valid_out.
- valid_out is high for one cycle per triggering pixel; otherwise 0.
- data_out_* update only when a window fires and hold their value otherwise.
- No window fires for c<4; this suppresses windows that straddle a row wrap. Windows per frame = (WIDTH-4)*(HEIGHT-4) = 64.
- Back-to-back valid_in gives back-to-back valid_out pulses within a row (e.g. pixels (4,4)..(4,11) give 8 consecutive pulses).
- Stale buffer contents from a previous frame never reach a fired window, because firing is gated by the counters.
- Reset, including mid-frame: row=0, col=0, valid_out=0, all data_out_*=0.
  - The shift buffer need not be cleared.
  - A valid_in coincident with rst is ignored.
  - The first pixel accepted after reset is (0,0).
- There is no backpressure; the downstream stage accepts every valid_out.
- Arithmetic: counters are sized as ceil(log2(WIDTH)) and ceil(log2(HEIGHT)) bits. Data is not modified.

Test Plan:
- Contiguous frame, data_in = raster index 0..143 with valid_in=1 every cycle:
  - First valid_out comes the cycle after index 52, with data_out_0=0, data_out_4=4, data_out_5=12, data_out_24=52.
  - Exactly 64 pulses in total; the last pulse has data_out_0=91 and data_out_24=143.
- Row wrap, same stream:
  - Pulses follow indices 52..59.
  - No pulse after indices 60..63.
  - The next pulse follows index 64, with data_out_0=12 and data_out_24=64.
- Gappy input, same frame with valid_in toggled pseudo-randomly (about 50% duty):
  - Same 64 windows in the same order with identical data.
  - Every valid_out is exactly 1 cycle after its triggering accept; valid_out=0 during idle gaps.
- Back-to-back frames, two frames of 0..143 with no gap:
  - No pulse on frame-2 indices 0..51.
  - Frame 2 produces 64 windows identical to frame 1; 128 pulses in total.
- Reset mid-frame, rst asserted for 1 cycle after index 70 is accepted, then a fresh 0..143 stream:
  - valid_out=0 and data_out_*=0 the cycle after rst.
  - First pulse follows the 53rd post-reset pixel, with data_out_0=0 and data_out_24=52.
- valid_in coincident with rst:
  - That pixel is not counted; the next accepted pixel is treated as (0,0).
